riscv_v_wb_buffer: RTL and testbench

RISCV_V_WB_BUFFER -- requirements
Module: riscv_v_wb_buffer

---
 rtl/riscv_v_pkg.sv | 34 +++
 rtl/riscv_v_wb_fifo.sv | 140 ++++++++++++++
 rtl/riscv_v_wb_buffer.sv | 107 ++++++++++
 tb/tb_riscv_v_wb_buffer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared types for the vector writeback buffer: payload widths, the stored
// entry layout and the occupancy state encoding.
package riscv_v_pkg;

    typedef logic [63:0] riscv_v_wb_data_t;
    typedef logic [31:0] riscv_data_t;
    typedef logic [7:0]  riscv_v_mask_t;
    typedef logic [4:0]  riscv_v_reg_addr_t;

    localparam int RISCV_V_WB_BE_W = $bits(riscv_v_wb_data_t) / 8;

    typedef logic [RISCV_V_WB_BE_W-1:0] riscv_v_wb_be_t;

    // One buffered result: payload for every target plus a pending bit per
    // target that is still owed a write.
    typedef struct packed {
        riscv_v_wb_data_t  vec_data;
        riscv_data_t       int_data;
        riscv_v_mask_t     mask_data;
        riscv_v_wb_be_t    vec_be;
        riscv_v_reg_addr_t vd;
        logic [4:0]        rd;
        logic              vec_pend;
        logic              int_pend;
        logic              mask_pend;
    } riscv_v_wb_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } riscv_v_wb_occ_e;

endpackage

// File: rtl/riscv_v_wb_fifo.sv
// Result storage for the writeback buffer: entry array, read/write pointers
// and the occupancy FSM. The head's pending bits can be cleared piecewise as
// individual targets complete.
//
// state       | meaning
// ------------+----------------------------------------------
// OCC_EMPTY   | no entries stored, head outputs meaningless
// OCC_PARTIAL | 1..DEPTH-1 entries stored, push and pop allowed
// OCC_FULL    | DEPTH entries stored, only pop allowed
module riscv_v_wb_fifo
    import riscv_v_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  riscv_v_wb_entry_t                    push_entry,
    input  logic                                 pop,
    input  logic                                 flush,
    input  logic                                 clr_vec,
    input  logic                                 clr_int,
    input  logic                                 clr_mask,
    output riscv_v_wb_entry_t                    head,
    output logic                                 head_valid,
    output logic                                 full,
    output logic [DEPTH-1:0]                     vec_pend,
    output logic [DEPTH-1:0]                     mask_pend,
    output riscv_v_reg_addr_t [DEPTH-1:0]        vd_list
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    riscv_v_wb_occ_e          state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
    riscv_v_wb_entry_t [DEPTH-1:0] mem_q;

    // Occupancy state and count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Occupancy next-state: push+pop together leaves count unchanged.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush) begin
            state_d = OCC_EMPTY;
            count_d = '0;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        count_d = CNT_W'(1);
                        state_d = OCC_PARTIAL;
                    end
                end
                OCC_PARTIAL: begin
                    if (push && !pop) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_d == CNT_W'(DEPTH)) state_d = OCC_FULL;
                    end else if (pop && !push) begin
                        count_d = count_q - CNT_W'(1);
                        if (count_d == '0) state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        count_d = count_q - CNT_W'(1);
                        state_d = OCC_PARTIAL;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                    count_d = '0;
                end
            endcase
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
    end

    // Entry storage; unoccupied slots always hold cleared pending bits so the
    // hazard bitmap can simply OR over every slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].vec_pend  <= 1'b0;
                mem_q[i].int_pend  <= 1'b0;
                mem_q[i].mask_pend <= 1'b0;
            end
        end else begin
            if (pop) begin
                mem_q[rd_ptr_q].vec_pend  <= 1'b0;
                mem_q[rd_ptr_q].int_pend  <= 1'b0;
                mem_q[rd_ptr_q].mask_pend <= 1'b0;
            end else begin
                if (clr_vec)  mem_q[rd_ptr_q].vec_pend  <= 1'b0;
                if (clr_int)  mem_q[rd_ptr_q].int_pend  <= 1'b0;
                if (clr_mask) mem_q[rd_ptr_q].mask_pend <= 1'b0;
            end
            if (push) mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head view and per-slot hazard information.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        head_valid = (state_q != OCC_EMPTY);
        full       = (state_q == OCC_FULL);
        for (int i = 0; i < DEPTH; i++) begin
            vec_pend[i]  = mem_q[i].vec_pend;
            mask_pend[i] = mem_q[i].mask_pend;
            vd_list[i]   = mem_q[i].vd;
        end
    end

endmodule

// File: rtl/riscv_v_wb_buffer.sv
// Vector writeback buffer: holds execute-stage results and drains them in
// order to the VRF, the integer pipeline and the v0 mask register. A head
// entry pops in the cycle its last outstanding target completes.
module riscv_v_wb_buffer
    import riscv_v_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_exe,
    output logic              ready_exe,
    input  riscv_v_wb_data_t  vec_result_exe,
    input  riscv_data_t       int_result_exe,
    input  riscv_v_mask_t     mask_result_exe,
    input  riscv_v_wb_be_t    vec_be_exe,
    input  riscv_v_reg_addr_t vd_exe,
    input  logic [4:0]        rd_exe,
    input  logic              is_vec_wb_exe,
    input  logic              is_int_wb_exe,
    input  logic              is_mask_wb_exe,
    input  logic              flush,
    output logic              vrf_wr_valid,
    input  logic              vrf_wr_ready,
    output riscv_v_reg_addr_t vrf_wr_addr,
    output riscv_v_wb_data_t  vrf_wr_data,
    output riscv_v_wb_be_t    vrf_wr_be,
    output logic              int_wb_valid,
    input  logic              int_wb_ready,
    output logic [4:0]        int_wb_addr,
    output riscv_data_t       int_wb_data,
    output logic              mask_wr_en,
    output riscv_v_mask_t     mask_wr_data,
    output logic [31:0]       busy_vreg
);

    riscv_v_wb_entry_t             push_entry, head;
    logic                          head_valid, full;
    logic                          push, pop;
    logic                          vec_done, int_done;
    logic [DEPTH-1:0]              vec_pend, mask_pend;
    riscv_v_reg_addr_t [DEPTH-1:0] vd_list;

    // Accept side: ready ignores valid and same-cycle pops; flag-less results
    // are acknowledged but never stored.
    always_comb begin
        ready_exe = !rst && !full && !flush;
        push      = valid_exe && ready_exe &&
                    (is_vec_wb_exe || is_int_wb_exe || is_mask_wb_exe);
        push_entry.vec_data  = vec_result_exe;
        push_entry.int_data  = int_result_exe;
        push_entry.mask_data = mask_result_exe;
        push_entry.vec_be    = vec_be_exe;
        push_entry.vd        = vd_exe;
        push_entry.rd        = rd_exe;
        push_entry.vec_pend  = is_vec_wb_exe;
        push_entry.int_pend  = is_int_wb_exe;
        push_entry.mask_pend = is_mask_wb_exe;
    end

    // Drain side: mask needs no handshake, so the head pops once the vector
    // and integer targets are both done or were never owed.
    always_comb begin
        vrf_wr_valid = head_valid && head.vec_pend;
        int_wb_valid = head_valid && head.int_pend;
        mask_wr_en   = head_valid && head.mask_pend;
        vrf_wr_addr  = head.vd;
        vrf_wr_data  = head.vec_data;
        vrf_wr_be    = head.vec_be;
        int_wb_addr  = head.rd;
        int_wb_data  = head.int_data;
        mask_wr_data = head.mask_data;
        vec_done     = !head.vec_pend || vrf_wr_ready;
        int_done     = !head.int_pend || int_wb_ready;
        pop          = head_valid && vec_done && int_done;
    end

    // Hazard bitmap: any stored vector write marks its vd, any mask write marks v0.
    always_comb begin
        busy_vreg = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vec_pend[i])  busy_vreg[vd_list[i]] = 1'b1;
            if (mask_pend[i]) busy_vreg[0]          = 1'b1;
        end
    end

    riscv_v_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .clr_vec    (vrf_wr_valid && vrf_wr_ready),
        .clr_int    (int_wb_valid && int_wb_ready),
        .clr_mask   (mask_wr_en),
        .head       (head),
        .head_valid (head_valid),
        .full       (full),
        .vec_pend   (vec_pend),
        .mask_pend  (mask_pend),
        .vd_list    (vd_list)
    );

endmodule

// File: tb/tb_riscv_v_wb_buffer.sv
// Bench for riscv_v_wb_buffer: a queue-based model of the buffer checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_riscv_v_wb_buffer;
    import riscv_v_pkg::*;

    localparam int DEPTH = 2;

    logic              clk, rst;
    logic              valid_exe, ready_exe;
    riscv_v_wb_data_t  vec_result_exe;
    riscv_data_t       int_result_exe;
    riscv_v_mask_t     mask_result_exe;
    riscv_v_wb_be_t    vec_be_exe;
    riscv_v_reg_addr_t vd_exe;
    logic [4:0]        rd_exe;
    logic              is_vec_wb_exe, is_int_wb_exe, is_mask_wb_exe;
    logic              flush;
    logic              vrf_wr_valid, vrf_wr_ready;
    riscv_v_reg_addr_t vrf_wr_addr;
    riscv_v_wb_data_t  vrf_wr_data;
    riscv_v_wb_be_t    vrf_wr_be;
    logic              int_wb_valid, int_wb_ready;
    logic [4:0]        int_wb_addr;
    riscv_data_t       int_wb_data;
    logic              mask_wr_en;
    riscv_v_mask_t     mask_wr_data;
    logic [31:0]       busy_vreg;

    int checks = 0;
    int errors = 0;

    riscv_v_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_exe       (valid_exe),
        .ready_exe       (ready_exe),
        .vec_result_exe  (vec_result_exe),
        .int_result_exe  (int_result_exe),
        .mask_result_exe (mask_result_exe),
        .vec_be_exe      (vec_be_exe),
        .vd_exe          (vd_exe),
        .rd_exe          (rd_exe),
        .is_vec_wb_exe   (is_vec_wb_exe),
        .is_int_wb_exe   (is_int_wb_exe),
        .is_mask_wb_exe  (is_mask_wb_exe),
        .flush           (flush),
        .vrf_wr_valid    (vrf_wr_valid),
        .vrf_wr_ready    (vrf_wr_ready),
        .vrf_wr_addr     (vrf_wr_addr),
        .vrf_wr_data     (vrf_wr_data),
        .vrf_wr_be       (vrf_wr_be),
        .int_wb_valid    (int_wb_valid),
        .int_wb_ready    (int_wb_ready),
        .int_wb_addr     (int_wb_addr),
        .int_wb_data     (int_wb_data),
        .mask_wr_en      (mask_wr_en),
        .mask_wr_data    (mask_wr_data),
        .busy_vreg       (busy_vreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a queue of outstanding results, each with the targets still owed.
    typedef struct {
        riscv_v_wb_data_t  v;
        riscv_data_t       i;
        riscv_v_mask_t     m;
        riscv_v_wb_be_t    be;
        riscv_v_reg_addr_t vd;
        logic [4:0]        rd;
        bit                pv;
        bit                pi;
        bit                pm;
    } ment_t;

    ment_t q[$];

    always @(negedge clk) begin : cmp
        ment_t       h, n;
        bit          h_ok, e_rdy, vdn, idn;
        logic [31:0] eb;
        e_rdy = !rst && !flush && (q.size() < DEPTH);
        h_ok  = !rst && (q.size() > 0);
        h     = '{default: '0};
        if (h_ok) h = q[0];
        eb = '0;
        if (!rst) begin
            foreach (q[k]) begin
                if (q[k].pv) eb[q[k].vd] = 1'b1;
                if (q[k].pm) eb[0] = 1'b1;
            end
        end
        chk("m_ready_exe", 64'(ready_exe), 64'(e_rdy));
        chk("m_vrf_wr_valid", 64'(vrf_wr_valid), 64'(h_ok && h.pv));
        if (h_ok && h.pv) begin
            chk("m_vrf_wr_addr", 64'(vrf_wr_addr), 64'(h.vd));
            chk("m_vrf_wr_data", 64'(vrf_wr_data), 64'(h.v));
            chk("m_vrf_wr_be", 64'(vrf_wr_be), 64'(h.be));
        end
        chk("m_int_wb_valid", 64'(int_wb_valid), 64'(h_ok && h.pi));
        if (h_ok && h.pi) begin
            chk("m_int_wb_addr", 64'(int_wb_addr), 64'(h.rd));
            chk("m_int_wb_data", 64'(int_wb_data), 64'(h.i));
        end
        chk("m_mask_wr_en", 64'(mask_wr_en), 64'(h_ok && h.pm));
        if (h_ok && h.pm) chk("m_mask_wr_data", 64'(mask_wr_data), 64'(h.m));
        chk("m_busy_vreg", 64'(busy_vreg), 64'(eb));

        if (rst) begin
            q.delete();
        end else begin
            if (h_ok) begin
                vdn = !h.pv || vrf_wr_ready;
                idn = !h.pi || int_wb_ready;
                if (vdn && idn) begin
                    void'(q.pop_front());
                end else begin
                    q[0].pv = h.pv && !vdn;
                    q[0].pi = h.pi && !idn;
                    q[0].pm = 1'b0;
                end
            end
            if (flush) begin
                q.delete();
            end else if (valid_exe && e_rdy && (is_vec_wb_exe || is_int_wb_exe || is_mask_wb_exe)) begin
                n.v  = vec_result_exe;
                n.i  = int_result_exe;
                n.m  = mask_result_exe;
                n.be = vec_be_exe;
                n.vd = vd_exe;
                n.rd = rd_exe;
                n.pv = is_vec_wb_exe;
                n.pi = is_int_wb_exe;
                n.pm = is_mask_wb_exe;
                q.push_back(n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        valid_exe      = 1'b0;
        is_vec_wb_exe  = 1'b0;
        is_int_wb_exe  = 1'b0;
        is_mask_wb_exe = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic present(input logic v, input logic i, input logic m,
                           input riscv_v_wb_data_t vdat, input riscv_data_t idat,
                           input riscv_v_mask_t mdat, input riscv_v_reg_addr_t vd,
                           input logic [4:0] rd);
        valid_exe       = 1'b1;
        is_vec_wb_exe   = v;
        is_int_wb_exe   = i;
        is_mask_wb_exe  = m;
        vec_result_exe  = vdat;
        int_result_exe  = idat;
        mask_result_exe = mdat;
        vec_be_exe      = 8'hFF;
        vd_exe          = vd;
        rd_exe          = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1'b1;
        idle();
        vrf_wr_ready    = 1'b0;
        int_wb_ready    = 1'b0;
        vec_result_exe  = '0;
        int_result_exe  = '0;
        mask_result_exe = '0;
        vec_be_exe      = '0;
        vd_exe          = '0;
        rd_exe          = '0;

        // Reset state
        mid();
        chk("rst_ready", 64'(ready_exe), 64'(0));
        chk("rst_vrf_valid", 64'(vrf_wr_valid), 64'(0));
        chk("rst_busy", 64'(busy_vreg), 64'(0));
        chk("rst_vrf_data", 64'(vrf_wr_data), 64'(0));
        chk("rst_int_data", 64'(int_wb_data), 64'(0));
        step(); step();
        rst = 1'b0;
        mid();
        chk("post_rst_ready", 64'(ready_exe), 64'(1));

        // Single vector result to v5
        step();
        vrf_wr_ready = 1'b1;
        int_wb_ready = 1'b1;
        present(1'b1, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 32'h0, 8'h0, 5'd5, 5'd0);
        mid();
        chk("s1_no_bypass", 64'(vrf_wr_valid), 64'(0));
        step();
        idle();
        mid();
        chk("s1_valid", 64'(vrf_wr_valid), 64'(1));
        chk("s1_addr", 64'(vrf_wr_addr), 64'(5));
        chk("s1_data", 64'(vrf_wr_data), 64'h1111_2222_3333_4444);
        chk("s1_busy", 64'(busy_vreg), 64'h20);
        step();
        mid();
        chk("s1_done", 64'(vrf_wr_valid), 64'(0));
        chk("s1_busy_clr", 64'(busy_vreg), 64'(0));

        // Vector + integer, integer stalled for three cycles
        step();
        int_wb_ready = 1'b0;
        present(1'b1, 1'b1, 1'b0, 64'h5555_6666_7777_8888, 32'hDEAD_BEEF, 8'h0, 5'd7, 5'd12);
        step();
        idle();
        mid();
        chk("s2_c1_vrf", 64'(vrf_wr_valid), 64'(1));
        chk("s2_c1_int", 64'(int_wb_valid), 64'(1));
        chk("s2_c1_busy", 64'(busy_vreg), 64'h80);
        step();
        mid();
        chk("s2_c2_vrf", 64'(vrf_wr_valid), 64'(0));
        chk("s2_c2_int", 64'(int_wb_valid), 64'(1));
        chk("s2_c2_data", 64'(int_wb_data), 64'hDEAD_BEEF);
        chk("s2_c2_busy", 64'(busy_vreg), 64'(0));
        step();
        mid();
        chk("s2_c3_data", 64'(int_wb_data), 64'hDEAD_BEEF);
        step();
        int_wb_ready = 1'b1;
        mid();
        chk("s2_c4_int", 64'(int_wb_valid), 64'(1));
        step();
        mid();
        chk("s2_c5_int", 64'(int_wb_valid), 64'(0));

        // Back-to-back results into a stalled buffer
        vrf_wr_ready = 1'b0;
        int_wb_ready = 1'b0;
        step();
        present(1'b1, 1'b0, 1'b0, 64'hA1, 32'h0, 8'h0, 5'd1, 5'd0);
        mid();
        chk("s3_d0_ready", 64'(ready_exe), 64'(1));
        step();
        present(1'b1, 1'b0, 1'b0, 64'hA2, 32'h0, 8'h0, 5'd2, 5'd0);
        mid();
        chk("s3_d1_ready", 64'(ready_exe), 64'(1));
        step();
        present(1'b1, 1'b0, 1'b0, 64'hA3, 32'h0, 8'h0, 5'd3, 5'd0);
        mid();
        chk("s3_d2_ready", 64'(ready_exe), 64'(0));
        chk("s3_d2_data", 64'(vrf_wr_data), 64'hA1);
        chk("s3_d2_busy", 64'(busy_vreg), 64'h6);
        step();
        vrf_wr_ready = 1'b1;
        mid();
        chk("s3_d3_ready", 64'(ready_exe), 64'(0));
        chk("s3_d3_data", 64'(vrf_wr_data), 64'hA1);
        step();
        mid();
        chk("s3_d4_ready", 64'(ready_exe), 64'(1));
        chk("s3_d4_data", 64'(vrf_wr_data), 64'hA2);
        step();
        idle();
        mid();
        chk("s3_d5_data", 64'(vrf_wr_data), 64'hA3);
        chk("s3_d5_busy", 64'(busy_vreg), 64'h8);
        step();
        mid();
        chk("s3_drained", 64'(vrf_wr_valid), 64'(0));

        // Mask-only result
        int_wb_ready = 1'b1;
        step();
        present(1'b0, 1'b0, 1'b1, 64'h0, 32'h0, 8'hA5, 5'd0, 5'd0);
        mid();
        chk("s4_pre_en", 64'(mask_wr_en), 64'(0));
        step();
        idle();
        mid();
        chk("s4_en", 64'(mask_wr_en), 64'(1));
        chk("s4_data", 64'(mask_wr_data), 64'hA5);
        chk("s4_busy", 64'(busy_vreg), 64'h1);
        step();
        mid();
        chk("s4_en_off", 64'(mask_wr_en), 64'(0));
        chk("s4_busy_clr", 64'(busy_vreg), 64'(0));

        // Mask + integer with integer stalled: mask pulses only once
        step();
        int_wb_ready = 1'b0;
        present(1'b0, 1'b1, 1'b1, 64'h0, 32'h5, 8'h3C, 5'd0, 5'd3);
        step();
        idle();
        mid();
        chk("s4b_en", 64'(mask_wr_en), 64'(1));
        chk("s4b_data", 64'(mask_wr_data), 64'h3C);
        chk("s4b_int", 64'(int_wb_valid), 64'(1));
        step();
        mid();
        chk("s4b_en_once", 64'(mask_wr_en), 64'(0));
        chk("s4b_int_hold", 64'(int_wb_valid), 64'(1));
        chk("s4b_busy", 64'(busy_vreg), 64'(0));
        step();
        int_wb_ready = 1'b1;
        step();
        mid();
        chk("s4b_done", 64'(int_wb_valid), 64'(0));

        // Accepted result with no targets is dropped
        step();
        present(1'b0, 1'b0, 1'b0, 64'hBAD, 32'hBAD, 8'hBA, 5'd9, 5'd9);
        mid();
        chk("s5_nop_ready", 64'(ready_exe), 64'(1));
        step();
        idle();
        mid();
        chk("s5_nop_vrf", 64'(vrf_wr_valid), 64'(0));
        chk("s5_nop_busy", 64'(busy_vreg), 64'(0));

        // Flush a full buffer
        vrf_wr_ready = 1'b0;
        int_wb_ready = 1'b0;
        step();
        present(1'b1, 1'b0, 1'b0, 64'hF4, 32'h0, 8'h0, 5'd4, 5'd0);
        step();
        present(1'b1, 1'b1, 1'b0, 64'hF6, 32'h99, 8'h0, 5'd6, 5'd9);
        step();
        idle();
        mid();
        chk("s6_full_ready", 64'(ready_exe), 64'(0));
        chk("s6_full_busy", 64'(busy_vreg), 64'h50);
        step();
        flush = 1'b1;
        mid();
        chk("s6_flush_ready", 64'(ready_exe), 64'(0));
        step();
        flush = 1'b0;
        mid();
        chk("s6_after_vrf", 64'(vrf_wr_valid), 64'(0));
        chk("s6_after_int", 64'(int_wb_valid), 64'(0));
        chk("s6_after_busy", 64'(busy_vreg), 64'(0));
        chk("s6_after_ready", 64'(ready_exe), 64'(1));

        // Asynchronous reset in the middle of a stalled handshake
        step();
        present(1'b1, 1'b0, 1'b0, 64'hE9, 32'h0, 8'h0, 5'd9, 5'd0);
        step();
        idle();
        mid();
        chk("s7_pending", 64'(vrf_wr_valid), 64'(1));
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("s7_rst_vrf", 64'(vrf_wr_valid), 64'(0));
        chk("s7_rst_busy", 64'(busy_vreg), 64'(0));
        chk("s7_rst_ready", 64'(ready_exe), 64'(0));
        chk("s7_rst_data", 64'(vrf_wr_data), 64'(0));
        mid();
        step();
        rst = 1'b0;
        mid();
        chk("s7_post_ready", 64'(ready_exe), 64'(1));
        chk("s7_post_vrf", 64'(vrf_wr_valid), 64'(0));

        // Mixed traffic with toggling backpressure, checked by the model
        k = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            vrf_wr_ready = (c % 3) != 0;
            int_wb_ready = (c % 2) == 0;
            if (k < 6)
                present((k % 2 == 0) || (k == 3), (k % 3 == 0), (k == 4),
                        64'hC0DE_0000 + 64'(k), 32'h100 + 32'(k), 8'(8'h40 + k),
                        5'(k + 10), 5'(k + 20));
            else
                idle();
            mid();
            if (k < 6 && ready_exe) k++;
        end
        chk("s8_accepts", 64'(k), 64'(6));
        chk("s8_empty_vrf", 64'(vrf_wr_valid), 64'(0));
        chk("s8_empty_int", 64'(int_wb_valid), 64'(0));
        chk("s8_empty_busy", 64'(busy_vreg), 64'(0));

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
